// File: rtl/mmio_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_decoder_pkg
// Description : Shared FSM encoding, core prefixes and helpers for the
//               MMIO decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'h0,
        ACCESS = 2'h1,
        RESP   = 2'h2
    } state_t;

    localparam logic [31:0] c_ILLEGAL_INSTRUCTION = 32'h0;

    localparam logic [5:0] c_PREFIX_TRNG        = 6'h00;
    localparam logic [5:0] c_PREFIX_TIMER       = 6'h01;
    localparam logic [5:0] c_PREFIX_UDS         = 6'h02;
    localparam logic [5:0] c_PREFIX_UART        = 6'h03;
    localparam logic [5:0] c_PREFIX_TOUCH_SENSE = 6'h04;
    localparam logic [5:0] c_PREFIX_FW_RAM      = 6'h10;
    localparam logic [5:0] c_PREFIX_TK1         = 6'h3f;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hff) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_decoder_if
// Description : CPU memory port and slave-side bus bundle for mmio_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_decoder_if #(
    parameter int NUM_SLAVES = 8
);
    logic                     cpu_valid;
    logic [31:0]              cpu_addr;
    logic [3:0]               cpu_wstrb;
    logic [31:0]              cpu_wdata;
    logic                     cpu_ready;
    logic [31:0]              cpu_rdata;

    logic [NUM_SLAVES-1:0]    slv_cs;
    logic                     slv_we;
    logic [7:0]               slv_address;
    logic [31:0]              slv_write_data;
    logic [NUM_SLAVES*32-1:0] slv_rdata;
    logic [NUM_SLAVES-1:0]    slv_ready;

    // CPU plus the attached cores, seen from outside the decoder
    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        input  slv_cs, slv_we, slv_address, slv_write_data,
        output slv_rdata, slv_ready
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_ready, cpu_rdata,
        output slv_cs, slv_we, slv_address, slv_write_data,
        input  slv_rdata, slv_ready
    );
endinterface
`default_nettype wire

// File: rtl/mmio_decoder_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : mmio_decoder_bus_timeout
// Description : 8-bit wait counter with clear/enable; flags the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_decoder_bus_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam logic [7:0] c_LAST = 8'(LIMIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Fires during the LIMIT-th enabled cycle so the response follows next
    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mmio_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_decoder
// Description : Table-driven MMIO slave decoder with timeout, firmware-only
//               access policy and error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_decoder
    import mmio_decoder_pkg::*;
#(
    parameter int                      NUM_SLAVES     = 8,
    parameter logic [6*NUM_SLAVES-1:0] SLAVE_PREFIXES = {NUM_SLAVES{c_PREFIX_TK1}},
    parameter logic [NUM_SLAVES-1:0]   FW_ONLY_MASK   = '0,
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERROR_DATA     = 32'h0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fw_app_mode,
    input  logic          force_trap,
    mmio_decoder_if.slave bus,
    output logic          bus_error,
    output logic [7:0]    err_count,
    output logic [31:0]   err_addr
);
    state_t                r_state;
    logic [3:0]            r_sel;
    logic [NUM_SLAVES-1:0] r_cs;
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_bus_error;
    logic [7:0]            r_err_count;
    logic [31:0]           r_err_addr;

    logic                  w_hit;
    logic [3:0]            w_idx;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_fw_only;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;
    logic                  w_expired;
    logic                  w_unused_addr;

    // Descending scan so the lowest matching slot is the one that sticks
    always_comb begin
        w_hit     = 1'b0;
        w_idx     = '0;
        w_onehot  = '0;
        w_fw_only = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (bus.cpu_addr[29:24] == SLAVE_PREFIXES[6*i +: 6]) begin
                w_hit       = 1'b1;
                w_idx       = 4'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_fw_only   = FW_ONLY_MASK[i];
            end
        end
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == 4'(i)) begin
                w_sel_ready = bus.slv_ready[i];
                w_sel_rdata = bus.slv_rdata[32*i +: 32];
            end
        end
    end

    mmio_decoder_bus_timeout #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_bus_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (r_state != ACCESS),
        .i_enable  (r_state == ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_cs        <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_bus_error <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_ready     <= 1'b0;
            r_bus_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        if (force_trap) begin
                            r_rdata <= c_ILLEGAL_INSTRUCTION;
                        end else if (!w_hit || (fw_app_mode && w_fw_only)) begin
                            r_rdata     <= ERROR_DATA;
                            r_bus_error <= 1'b1;
                            r_err_count <= sat_inc8(r_err_count);
                            r_err_addr  <= bus.cpu_addr;
                        end else begin
                            r_state <= ACCESS;
                            r_ready <= 1'b0;
                            r_sel   <= w_idx;
                            r_cs    <= w_onehot;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout in the same cycle
                    if (w_sel_ready || w_expired) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_cs    <= '0;
                        if (w_sel_ready) begin
                            r_rdata <= w_sel_rdata;
                        end else begin
                            r_rdata     <= ERROR_DATA;
                            r_bus_error <= 1'b1;
                            r_err_count <= sat_inc8(r_err_count);
                            r_err_addr  <= bus.cpu_addr;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready      = r_ready;
    assign bus.cpu_rdata      = r_rdata;
    assign bus.slv_cs         = r_cs;
    assign bus.slv_we         = |bus.cpu_wstrb;
    assign bus.slv_address    = bus.cpu_addr[9:2];
    assign bus.slv_write_data = bus.cpu_wdata;
    assign bus_error          = r_bus_error;
    assign err_count          = r_err_count;
    assign err_addr           = r_err_addr;

    assign w_unused_addr = &{1'b0, bus.cpu_addr[31:30], bus.cpu_addr[23:10], bus.cpu_addr[1:0]};

endmodule
`default_nettype wire
